dff_bank_ctrl: RTL and testbench

Controller and arbiter for a WIDTH-bit storage bank built from `dff` cells (per-bit data, shared clk, bank-wide set/reset). Up to NREQ requesters share the bank through a round-robin req/gnt/ack handshake. Each granted requester issues one operation: LOAD, CLEAR, PRESET or READ. The block drives the bank's data, set and reset lines, and checks the bank's q outputs after each operation.

---
 rtl/dff_bank_pkg.sv | 16 +
 rtl/dff_bank_ctrl_if.sv | 24 ++
 rtl/dff.sv | 16 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/dff_bank_ctrl.sv | 121 ++++++++++++
 tb/tb_dff_bank_ctrl.sv | 194 +++++++++++++++++++
 6 files changed

// File: rtl/dff_bank_pkg.sv
// Shared encodings for the dff bank controller: requester op codes and FSM states.
package dff_bank_pkg;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/dff_bank_ctrl_if.sv
// Requester-side handshake bundle of the dff bank controller (req/gnt/ack plus op payload and results).
interface dff_bank_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic [WIDTH-1:0]      rdata;
  logic                  err;
  logic                  busy;

  modport master (
    output req, op, wdata,
    input  gnt, ack, rdata, err, busy
  );

  modport slave (
    input  req, op, wdata,
    output gnt, ack, rdata, err, busy
  );
endinterface

// File: rtl/dff.sv
// Single storage cell of the bank: synchronous reset has priority over set, otherwise captures d.
module dff (
  input  logic clk,
  input  logic d,
  input  logic set,
  input  logic reset,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)    q <= 1'b0;
    else if (set) q <= 1'b1;
    else          q <= d;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_ctrl.sv
// Arbitrates requesters onto a dff bank, drives its data/set/reset lines from a shadow copy
// and verifies the bank's q outputs against that shadow after every operation.
module dff_bank_ctrl
  import dff_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic             clk,
  input  logic             reset,
  dff_bank_ctrl_if.slave   bus,
  input  logic [WIDTH-1:0] bank_q,
  output logic [WIDTH-1:0] bank_data,
  output logic             bank_set,
  output logic             bank_reset
);

  localparam int              PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, win_q, arb_idx;
  logic [NREQ-1:0]  arb_gnt, gnt_q;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] wdata_sel, shadow_q, shadow_d, rdata_q;
  logic             set_q, set_d, brst_q, brst_d;
  logic             ack_q, err_q, start;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx   = '0;
    op_sel    = OP_READ;
    wdata_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        arb_idx   = PTR_W'(i);
        op_sel    = bus.op[2*i +: 2];
        wdata_sel = bus.wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  // The winner's op takes effect at the grant edge so the DRIVE cycle presents it to the bank.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shadow_d = shadow_q;
    set_d    = 1'b0;
    brst_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          start   = 1'b1;
          state_d = DRIVE;
          case (op_sel)
            OP_LOAD:   shadow_d = wdata_sel;
            OP_CLEAR:  begin shadow_d = '0; brst_d = 1'b1; end
            OP_PRESET: begin shadow_d = '1; set_d  = 1'b1; end
            default:   shadow_d = shadow_q;
          endcase
        end
      end
      DRIVE:   state_d = CHECK;
      CHECK:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Reset also pulses bank_reset so the bank clears in step with the controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      gnt_q    <= '0;
      ptr_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      set_q    <= 1'b0;
      brst_q   <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      set_q    <= set_d;
      brst_q   <= brst_d;
      ack_q    <= (state_q == CHECK);
      if (start) gnt_q <= arb_gnt;
      if (state_q == CHECK) begin
        err_q   <= (bank_q != shadow_q);
        rdata_q <= bank_q;
      end
      if (state_q == DONE) begin
        gnt_q <= '0;
        ptr_q <= (win_q == LAST) ? '0 : win_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) win_q <= arb_idx;
  end

  assign bank_data  = shadow_q;
  assign bank_set   = set_q;
  assign bank_reset = brst_q;
  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dff_bank_ctrl.sv
// Directed bench for dff_bank_ctrl driving a real bank of dff cells with readback fault injection.
module tb_dff_bank_ctrl;
  import dff_bank_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] bank_data, cell_q, bank_q, force_mask;
  logic             bank_set, bank_reset;
  int               checks = 0;
  int               errors = 0;

  dff_bank_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  dff_bank_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .bank_q     (bank_q),
    .bank_data  (bank_data),
    .bank_set   (bank_set),
    .bank_reset (bank_reset)
  );

  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    dff u_cell (
      .clk   (clk),
      .d     (bank_data[b]),
      .set   (bank_set),
      .reset (bank_reset),
      .q     (cell_q[b])
    );
  end

  assign bank_q = cell_q & ~force_mask;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] o, input logic [7:0] d);
    bus.req[r]              = 1'b1;
    bus.op[2*r +: 2]        = o;
    bus.wdata[WIDTH*r +: WIDTH] = d;
  endtask

  // One complete operation by a single requester, checked edge by edge.
  task automatic run_op(input string tag, input int r, input logic [1:0] o, input logic [7:0] d,
                        input logic [7:0] exp_q, input logic exp_err);
    logic [3:0] g;
    g = 4'b0001 << r;
    set_req(r, o, d);
    tick();
    chk({tag, " gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " set pulse"}, 32'(bank_set), 32'(o == OP_PRESET));
    chk({tag, " reset pulse"}, 32'(bank_reset), 32'(o == OP_CLEAR));
    tick();
    chk({tag, " set low"}, 32'(bank_set | bank_reset), 32'd0);
    chk({tag, " bank_q"}, 32'(bank_q), 32'(exp_q));
    chk({tag, " no early ack"}, 32'(bus.ack), 32'd0);
    tick();
    chk({tag, " ack"}, 32'(bus.ack), 32'd1);
    chk({tag, " rdata"}, 32'(bus.rdata), 32'(exp_q));
    chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
    bus.req[r] = 1'b0;
    tick();
    chk({tag, " ack drop"}, 32'(bus.ack), 32'd0);
    chk({tag, " gnt clear"}, 32'(bus.gnt), 32'd0);
    chk({tag, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    force_mask = '0;
    bus.req    = '0;
    bus.op     = '0;
    bus.wdata  = '0;
    tick();
    tick();
    chk("rst gnt", 32'(bus.gnt), 32'd0);
    chk("rst ack", 32'(bus.ack), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst bank_reset", 32'(bank_reset), 32'd1);
    chk("rst bank_set", 32'(bank_set), 32'd0);
    chk("rst bank_data", 32'(bank_data), 32'd0);
    chk("rst rdata", 32'(bus.rdata), 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();
    chk("post rst bank_reset", 32'(bank_reset), 32'd0);
    chk("post rst bank_q", 32'(bank_q), 32'd0);

    run_op("load A5", 1, OP_LOAD, 8'hA5, 8'hA5, 1'b0);
    tick();
    chk("hold bank_data", 32'(bank_data), 32'hA5);
    chk("hold bank_q", 32'(bank_q), 32'hA5);

    run_op("load 3C", 0, OP_LOAD, 8'h3C, 8'h3C, 1'b0);
    run_op("preset", 2, OP_PRESET, 8'h00, 8'hFF, 1'b0);
    run_op("clear", 3, OP_CLEAR, 8'hFF, 8'h00, 1'b0);

    // Pointer is back at 0: continuous READs from everyone rotate 0,1,2,3,0.
    for (int r = 0; r < NREQ; r++) set_req(r, OP_READ, 8'h00);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr gnt", 32'(bus.gnt), 32'(4'b0001 << (k % 4)));
      chk("rr ack0", 32'(bus.ack), 32'd0);
      tick();
      chk("rr ack1", 32'(bus.ack), 32'd0);
      tick();
      chk("rr ack", 32'(bus.ack), 32'd1);
      chk("rr gnt hold", 32'(bus.gnt), 32'(4'b0001 << (k % 4)));
      chk("rr rdata", 32'(bus.rdata), 32'd0);
      tick();
      chk("rr ack3", 32'(bus.ack), 32'd0);
      chk("rr gnt gap", 32'(bus.gnt), 32'd0);
    end
    bus.req = '0;
    tick();

    force_mask = 8'h01;
    run_op("mismatch", 1, OP_LOAD, 8'h01, 8'h00, 1'b1);
    force_mask = '0;

    set_req(2, OP_LOAD, 8'h77);
    tick();
    chk("cut gnt", 32'(bus.gnt), 32'b0100);
    tick();
    reset = 1'b1;
    tick();
    chk("cut ack", 32'(bus.ack), 32'd0);
    chk("cut gnt clear", 32'(bus.gnt), 32'd0);
    chk("cut bank_reset", 32'(bank_reset), 32'd1);
    reset   = 1'b0;
    bus.req = '0;
    tick();
    chk("cut ack after", 32'(bus.ack), 32'd0);
    chk("cut bank_reset off", 32'(bank_reset), 32'd0);
    chk("cut bank_q", 32'(bank_q), 32'd0);

    set_req(0, OP_LOAD, 8'h11);
    set_req(3, OP_LOAD, 8'h22);
    tick();
    chk("prio gnt0", 32'(bus.gnt), 32'b0001);
    tick();
    tick();
    chk("prio ack0", 32'(bus.ack), 32'd1);
    chk("prio rdata0", 32'(bus.rdata), 32'h11);
    bus.req[0] = 1'b0;
    tick();
    tick();
    chk("prio gnt3", 32'(bus.gnt), 32'b1000);
    tick();
    tick();
    chk("prio ack3", 32'(bus.ack), 32'd1);
    chk("prio rdata3", 32'(bus.rdata), 32'h22);
    bus.req = '0;
    tick();

    set_req(2, OP_READ, 8'h00);
    tick();
    chk("drop gnt", 32'(bus.gnt), 32'b0100);
    bus.req = '0;
    tick();
    tick();
    chk("drop ack", 32'(bus.ack), 32'd1);
    chk("drop rdata", 32'(bus.rdata), 32'h22);
    tick();
    chk("drop ack off", 32'(bus.ack), 32'd0);
    tick();
    chk("drop no regrant", 32'(bus.gnt), 32'd0);
    chk("drop idle", 32'(bus.busy), 32'd0);
    tick();
    chk("drop no ack", 32'(bus.ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
